html_char_streamer: RTL and testbench

- Producer side of the character stream that the HTML parser consumes.
- Fetches the HTML document byte by byte from a synchronous on-chip ROM.
- Normalises whitespace and presents one character at a time under a valid/ack handshake.
- Signals end of document so the top level can deassert the parser's enable.

---
 rtl/html_char_streamer_pkg.sv | 23 ++
 rtl/html_char_streamer_if.sv | 20 ++
 rtl/html_ws_classifier.sv | 29 ++
 rtl/html_char_streamer.sv | 134 +++++++++++++
 tb/tb_html_char_streamer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/html_char_streamer_pkg.sv
// Shared constants and state encoding for the HTML character streamer
// and the parsers that consume its output.
package html_char_streamer_pkg;

    localparam int CHAR_WIDTH_DEF = 8;

    localparam logic [7:0] ASCII_NUL   = 8'h00;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LT    = 8'h3C;
    localparam logic [7:0] ASCII_GT    = 8'h3E;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_EVAL    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/html_char_streamer_if.sv
// Character stream handshake between the streamer and the parser.
interface html_char_streamer_if #(
    parameter int CHAR_WIDTH = 8
);
    logic [CHAR_WIDTH-1:0] char;
    logic                  char_valid;
    logic                  char_ack;

    modport master (
        output char,
        output char_valid,
        input  char_ack
    );

    modport slave (
        input  char,
        input  char_valid,
        output char_ack
    );
endinterface

// File: rtl/html_ws_classifier.sv
// Combinational byte classifier: NUL detect, whitespace collapse decision
// and normalised output character.
module html_ws_classifier
    import html_char_streamer_pkg::*;
#(
    parameter int CHAR_WIDTH  = CHAR_WIDTH_DEF,
    parameter int COLLAPSE_WS = 1
) (
    input  logic [CHAR_WIDTH-1:0] in_byte,
    input  logic                  prev_ws,
    output logic                  is_nul,
    output logic                  is_ws,
    output logic                  skip,
    output logic [CHAR_WIDTH-1:0] out_char
);

    localparam logic COLLAPSE = (COLLAPSE_WS != 0);

    always_comb begin
        is_nul   = (in_byte == CHAR_WIDTH'(ASCII_NUL));
        is_ws    = (in_byte == CHAR_WIDTH'(ASCII_SPACE))
                || (in_byte == CHAR_WIDTH'(ASCII_TAB))
                || (in_byte == CHAR_WIDTH'(ASCII_LF))
                || (in_byte == CHAR_WIDTH'(ASCII_CR));
        skip     = COLLAPSE && is_ws && prev_ws;
        out_char = (COLLAPSE && is_ws) ? CHAR_WIDTH'(ASCII_SPACE) : in_byte;
    end

endmodule

// File: rtl/html_char_streamer.sv
// Streams a NUL-terminated HTML document out of a synchronous ROM,
// one normalised character per valid/ack handshake.
module html_char_streamer
    import html_char_streamer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int CHAR_WIDTH  = CHAR_WIDTH_DEF,
    parameter int COLLAPSE_WS = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [CHAR_WIDTH-1:0] rom_data,
    html_char_streamer_if.master  cs,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   char_count
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [CHAR_WIDTH-1:0] char_q, char_d;
    logic                  prev_ws_q, prev_ws_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  advance;

    logic                  ws_is_nul;
    logic                  ws_is_ws;
    logic                  ws_skip;
    logic [CHAR_WIDTH-1:0] ws_char;

    html_ws_classifier #(
        .CHAR_WIDTH  (CHAR_WIDTH),
        .COLLAPSE_WS (COLLAPSE_WS)
    ) u_ws (
        .in_byte  (rom_data),
        .prev_ws  (prev_ws_q),
        .is_nul   (ws_is_nul),
        .is_ws    (ws_is_ws),
        .skip     (ws_skip),
        .out_char (ws_char)
    );

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        char_d     = char_q;
        prev_ws_d  = prev_ws_q;
        busy_d     = busy_q;
        done_d     = done_q;
        count_d    = count_q;
        advance    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    rom_addr_d = '0;
                    count_d    = '0;
                    prev_ws_d  = 1'b1;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_READ;
                end
            end
            ST_READ: state_d = ST_EVAL;
            ST_EVAL: begin
                if (ws_is_nul) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (ws_skip) begin
                    advance = 1'b1;
                end else begin
                    char_d    = ws_char;
                    prev_ws_d = ws_is_ws;
                    state_d   = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (cs.char_ack) begin
                    count_d = count_q + CNT_ONE;
                    advance = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The last ROM byte ends the document instead of wrapping to 0.
        if (advance) begin
            if (rom_addr_q == {ADDR_WIDTH{1'b1}}) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end else begin
                rom_addr_d = rom_addr_q + ADDR_ONE;
                state_d    = ST_READ;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            char_q     <= '0;
            prev_ws_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            char_q     <= char_d;
            prev_ws_q  <= prev_ws_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
        end
    end

    assign rom_addr      = rom_addr_q;
    assign cs.char       = char_q;
    assign cs.char_valid = (state_q == ST_PRESENT);
    assign busy          = busy_q;
    assign done          = done_q;
    assign char_count    = count_q;

endmodule

// File: tb/tb_html_char_streamer.sv
// Bench for html_char_streamer: collapsing, raw and 3-bit-address instances,
// each fed by a behavioural synchronous ROM.
module tb_html_char_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b, start_c;
    logic [11:0] addr_a, addr_b;
    logic [2:0]  addr_c;
    logic [7:0]  rd_a, rd_b, rd_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;
    logic [12:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    logic [7:0] mem_a [4096];
    logic [7:0] mem_b [4096];
    logic [7:0] mem_c [8];

    html_char_streamer_if #(.CHAR_WIDTH(8)) ifa ();
    html_char_streamer_if #(.CHAR_WIDTH(8)) ifb ();
    html_char_streamer_if #(.CHAR_WIDTH(8)) ifc ();

    html_char_streamer #(.ADDR_WIDTH(12), .CHAR_WIDTH(8), .COLLAPSE_WS(1)) dut_a (
        .clock(clk), .resetn(rst_n), .start(start_a), .rom_addr(addr_a),
        .rom_data(rd_a), .cs(ifa.master), .busy(busy_a), .done(done_a),
        .char_count(cnt_a));

    html_char_streamer #(.ADDR_WIDTH(12), .CHAR_WIDTH(8), .COLLAPSE_WS(0)) dut_b (
        .clock(clk), .resetn(rst_n), .start(start_b), .rom_addr(addr_b),
        .rom_data(rd_b), .cs(ifb.master), .busy(busy_b), .done(done_b),
        .char_count(cnt_b));

    html_char_streamer #(.ADDR_WIDTH(3), .CHAR_WIDTH(8), .COLLAPSE_WS(1)) dut_c (
        .clock(clk), .resetn(rst_n), .start(start_c), .rom_addr(addr_c),
        .rom_data(rd_c), .cs(ifc.master), .busy(busy_c), .done(done_c),
        .char_count(cnt_c));

    always @(posedge clk) begin
        rd_a <= mem_a[addr_a];
        rd_b <= mem_b[addr_b];
        rd_c <= mem_c[addr_c];
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qc[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input int act);
        total++;
        bad++;
        $display("FAIL %s: got %0h want none", name, act);
    endtask

    // Scoreboard: every consumed character is popped and compared.
    always @(negedge clk) begin
        if (ifa.char_valid && ifa.char_ack) begin
            if (qa.size() == 0) extra("a_char", int'(ifa.char));
            else chk("a_char", int'(ifa.char), int'(qa.pop_front()));
        end
        if (ifb.char_valid && ifb.char_ack) begin
            if (qb.size() == 0) extra("b_char", int'(ifb.char));
            else chk("b_char", int'(ifb.char), int'(qb.pop_front()));
        end
        if (ifc.char_valid && ifc.char_ack) begin
            if (qc.size() == 0) extra("c_char", int'(ifc.char));
            else chk("c_char", int'(ifc.char), int'(qc.pop_front()));
        end
    end

    function automatic int done_of(input int w);
        case (w)
            0: return int'(done_a);
            1: return int'(done_b);
            default: return int'(done_c);
        endcase
    endfunction

    function automatic int busy_of(input int w);
        case (w)
            0: return int'(busy_a);
            1: return int'(busy_b);
            default: return int'(busy_c);
        endcase
    endfunction

    function automatic int count_of(input int w);
        case (w)
            0: return int'(cnt_a);
            1: return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    function automatic int qsize(input int w);
        case (w)
            0: return qa.size();
            1: return qb.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic push(input int w, input logic [7:0] b);
        case (w)
            0: qa.push_back(b);
            1: qb.push_back(b);
            default: qc.push_back(b);
        endcase
    endtask

    task automatic push_str(input int w, input string s);
        for (int k = 0; k < s.len(); k++) push(w, s[k]);
    endtask

    task automatic load(input int w, input string s);
        for (int k = 0; k < s.len(); k++) begin
            if (w == 0) mem_a[k] = s[k];
            else mem_b[k] = s[k];
        end
        if (w == 0) mem_a[s.len()] = 8'h00;
        else mem_b[s.len()] = 8'h00;
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic pulse_start(input int w);
        @(posedge clk);
        #1 set_start(w, 1'b1);
        @(posedge clk);
        #1 set_start(w, 1'b0);
    endtask

    task automatic wait_done(input int w, input string name);
        int n = 0;
        while (done_of(w) == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, done_of(w), 1);
    endtask

    task automatic wait_valid_a(input string name);
        int n = 0;
        while (!ifa.char_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(ifa.char_valid), 1);
    endtask

    typedef struct {
        string rom;
        int    w;
        string exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        automatic int n;
        automatic bit ok;

        vecs[0] = '{rom: "<b>hi</b>",            w: 0, exp: "<b>hi</b>"};
        vecs[1] = '{rom: "  a \t\n b",           w: 0, exp: "a b"};
        vecs[2] = '{rom: "x   y  ",              w: 0, exp: "x y "};
        vecs[3] = '{rom: "\t\015\n",             w: 0, exp: ""};
        vecs[4] = '{rom: "",                     w: 0, exp: ""};
        vecs[5] = '{rom: "A\015B",               w: 0, exp: "A B"};
        vecs[6] = '{rom: "  a \t\n b",           w: 1, exp: "  a \t\n b"};
        vecs[7] = '{rom: "a\015\nb",             w: 1, exp: "a\015\nb"};

        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        ifa.char_ack = 1'b0; ifb.char_ack = 1'b0; ifc.char_ack = 1'b0;
        #12;
        chk("rst_addr", int'(addr_a), 0);
        chk("rst_char", int'(ifa.char), 0);
        chk("rst_valid", int'(ifa.char_valid), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_count", int'(cnt_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        @(posedge clk);
        #1 ifa.char_ack = 1'b1; ifb.char_ack = 1'b1; ifc.char_ack = 1'b1;

        for (int i = 0; i < 8; i++) begin
            load(vecs[i].w, vecs[i].rom);
            push_str(vecs[i].w, vecs[i].exp);
            pulse_start(vecs[i].w);
            wait_done(vecs[i].w, $sformatf("v%0d_done", i));
            @(negedge clk);
            chk($sformatf("v%0d_count", i), count_of(vecs[i].w), vecs[i].exp.len());
            chk($sformatf("v%0d_busy", i), busy_of(vecs[i].w), 0);
            chk($sformatf("v%0d_left", i), qsize(vecs[i].w), 0);
        end

        // Consumer stalls for 20 cycles on the first character.
        @(posedge clk);
        #1 ifa.char_ack = 1'b0;
        load(0, "xy");
        push_str(0, "xy");
        pulse_start(0);
        wait_valid_a("stall_valid");
        chk("stall_first", int'(ifa.char), 8'h78);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!(ifa.char_valid && ifa.char == 8'h78)) ok = 1'b0;
        end
        chk("stall_hold", int'(ok), 1);
        @(posedge clk);
        #1 ifa.char_ack = 1'b1;
        n = 0;
        while (n < 10) begin
            @(posedge clk);
            #1 n++;
            if (ifa.char_valid && ifa.char == 8'h79) break;
        end
        chk("stall_release_lat", n, 3);
        wait_done(0, "stall_done");
        @(negedge clk);
        chk("stall_count", int'(cnt_a), 2);
        chk("stall_left", qa.size(), 0);

        // Start held high mid-stream, then restart from DONE.
        load(0, "<b>hi</b>");
        push_str(0, "<b>hi</b>");
        pulse_start(0);
        repeat (4) @(posedge clk);
        #1 start_a = 1'b1;
        repeat (6) @(posedge clk);
        #1 start_a = 1'b0;
        wait_done(0, "busy_start_done");
        @(negedge clk);
        chk("busy_start_count", int'(cnt_a), 9);
        chk("busy_start_left", qa.size(), 0);
        push_str(0, "<b>hi</b>");
        pulse_start(0);
        chk("restart_done_low", int'(done_a), 0);
        chk("restart_busy", int'(busy_a), 1);
        wait_done(0, "restart_done");
        @(negedge clk);
        chk("restart_count", int'(cnt_a), 9);
        chk("restart_left", qa.size(), 0);

        // Full 8-byte ROM with no terminator.
        for (int k = 0; k < 8; k++) mem_c[k] = 8'h61 + 8'(k);
        push_str(2, "abcdefgh");
        pulse_start(2);
        wait_done(2, "full_done");
        @(negedge clk);
        chk("full_count", int'(cnt_c), 8);
        chk("full_addr", int'(addr_c), 7);
        repeat (5) @(negedge clk);
        chk("full_addr_hold", int'(addr_c), 7);
        chk("full_valid", int'(ifc.char_valid), 0);
        chk("full_left", qc.size(), 0);

        // Asynchronous reset while presenting 'h'.
        @(posedge clk);
        #1 ifa.char_ack = 1'b0;
        load(0, "hello");
        pulse_start(0);
        wait_valid_a("rstm_valid");
        chk("rstm_char", int'(ifa.char), 8'h68);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_addr", int'(addr_a), 0);
        chk("rstm_char0", int'(ifa.char), 0);
        chk("rstm_valid", int'(ifa.char_valid), 0);
        chk("rstm_busy", int'(busy_a), 0);
        chk("rstm_done", int'(done_a), 0);
        chk("rstm_count", int'(cnt_a), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ifa.char_ack = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ifa.char_valid) ok = 1'b0;
        end
        chk("rstm_quiet", int'(ok), 1);
        chk("rstm_idle_count", int'(cnt_a), 0);
        push_str(0, "hello");
        pulse_start(0);
        wait_done(0, "rstm_done2");
        @(negedge clk);
        chk("rstm_count2", int'(cnt_a), 5);
        chk("rstm_left", qa.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
